// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver.
// Digits are scanned one slot at a time with a dead-time gap at each slot start.
// New digit data is staged in a pending set and copied to the display set only on
// the frame boundary, so a frame never mixes old and new digits.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_en,
    input  logic                    lzb_en,
    input  logic                    load,
    output logic                    update_pending,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // One complete set of everything the display needs for a frame.
    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] codes;
        logic [NUM_DIGITS-1:0]      dps;
        logic                       hex;
        logic                       lzb;
    } disp_set_t;

    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    disp_set_t             disp, disp_nxt, pend, in_set;
    logic                  pend_valid;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_run;
    logic [3:0]            code_sel;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [NUM_DIGITS-1:0] dig_nxt;
    logic                  fd_nxt;

    // Active-high segment pattern for a 4-bit code; 10-15 only lit in hex mode.
    function automatic logic [6:0] decode7(input logic [3:0] code, input logic hex);
        logic [6:0] pat;
        case (code)
            4'h0: pat = 7'b1111110;
            4'h1: pat = 7'b0110000;
            4'h2: pat = 7'b1101101;
            4'h3: pat = 7'b1111001;
            4'h4: pat = 7'b0110011;
            4'h5: pat = 7'b1011011;
            4'h6: pat = 7'b1011111;
            4'h7: pat = 7'b1110000;
            4'h8: pat = 7'b1111111;
            4'h9: pat = 7'b1111011;
            4'hA: pat = hex ? 7'b1110111 : 7'b0000000;
            4'hB: pat = hex ? 7'b0011111 : 7'b0000000;
            4'hC: pat = hex ? 7'b1001110 : 7'b0000000;
            4'hD: pat = hex ? 7'b0111101 : 7'b0000000;
            4'hE: pat = hex ? 7'b1001111 : 7'b0000000;
            default: pat = hex ? 7'b1000111 : 7'b0000000;
        endcase
        return pat;
    endfunction

    // Next scan position, next display set, and the outputs that position implies.
    // Outputs are registered from the *next* state so they line up with cnt/idx.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path can leave one unassigned and infer a latch.
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        in_set    = {data_in, dp_in, hex_en, lzb_en};
        disp_nxt  = disp;
        lead_zero = '0;
        zero_run  = 1'b1;
        seg_nxt   = 7'b0000000;
        dp_nxt    = 1'b0;
        dig_nxt   = '0;
        code_sel  = 4'h0;

        boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);

        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end

        if (boundary)
            disp_nxt = load ? in_set : (pend_valid ? pend : disp);

        // A digit is a leading zero if it and every digit above it is a bare 0.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run & (disp_nxt.codes[k] == 4'h0) & ~disp_nxt.dps[k];
            lead_zero[k] = zero_run;
        end

        fd_nxt = (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);

        if (int'(cnt_nxt) >= BLANK_CYCLES) begin
            code_sel = disp_nxt.codes[idx_nxt];
            dig_nxt  = NUM_DIGITS'(1) << idx_nxt;
            dp_nxt   = disp_nxt.dps[idx_nxt];
            if (disp_nxt.lzb && (idx_nxt != '0) && lead_zero[idx_nxt])
                seg_nxt = 7'b0000000;
            else
                seg_nxt = decode7(code_sel, disp_nxt.hex);
        end
    end

    // Scan counters, display/pending sets and registered pin outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register samples
        // the pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt            <= '0;
            idx            <= '0;
            disp           <= '0;
            pend           <= '0;
            pend_valid     <= 1'b0;
            update_pending <= 1'b0;
            frame_done     <= 1'b0;
            seg            <= {7{SEG_ACTIVE_LOW}};
            dp             <= SEG_ACTIVE_LOW;
            dig_en         <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            cnt  <= cnt_nxt;
            idx  <= idx_nxt;
            disp <= disp_nxt;
            if (boundary) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pend       <= in_set;
                pend_valid <= 1'b1;
            end
            update_pending <= boundary ? 1'b0 : (pend_valid | load);
            frame_done     <= fd_nxt;
            seg            <= seg_nxt ^ {7{SEG_ACTIVE_LOW}};
            dp             <= dp_nxt ^ SEG_ACTIVE_LOW;
            dig_en         <= dig_nxt ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (N=4, CLK_DIV=8, BLANK_CYCLES=2).
// A cycle-count model predicts every output of two builds (seg active-high and
// seg active-low); directed vectors add hand-computed literal expectations.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;

    localparam logic [6:0] FONT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct packed {
        logic [15:0] codes;
        logic [3:0]  dps;
        logic        hex;
        logic        lzb;
    } disp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic        hex_en = 1'b0;
    logic        lzb_en = 1'b0;
    logic        load = 1'b0;

    logic       up0, dp0, fd0, up1, dp1, fd1;
    logic [6:0] seg0, seg1;
    logic [3:0] dig0, dig1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLANK),
                       .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .hex_en(hex_en), .lzb_en(lzb_en), .load(load),
        .update_pending(up0), .seg(seg0), .dp(dp0), .dig_en(dig0), .frame_done(fd0));

    seg7_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYCLES(BLANK),
                       .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in),
        .hex_en(hex_en), .lzb_en(lzb_en), .load(load),
        .update_pending(up1), .seg(seg1), .dp(dp1), .dig_en(dig1), .frame_done(fd1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit    m_ok = 1'b0;
    int    m_cyc = 0;
    bit    m_pv = 1'b0;
    disp_t m_disp = '0;
    disp_t m_pend = '0;
    disp_t in_now;

    assign in_now = {data_in, dp_in, hex_en, lzb_en};

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok   <= 1'b1;
            m_cyc  <= 0;
            m_disp <= '0;
            m_pend <= '0;
            m_pv   <= 1'b0;
        end else begin
            if (m_cyc % FRAME == FRAME - 1) begin
                m_disp <= load ? in_now : (m_pv ? m_pend : m_disp);
                m_pv   <= 1'b0;
            end else if (load) begin
                m_pend <= in_now;
                m_pv   <= 1'b1;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    // {seg, dp, dig_en, frame_done} at the pins for a given cycle and display set.
    function automatic logic [12:0] expect_out(input int cyc, input disp_t d, input bit seg_low);
        int         phase = cyc % DIV;
        int         slot  = (cyc / DIV) % N;
        logic [6:0] s  = 7'b0;
        logic       p  = 1'b0;
        logic [3:0] g  = 4'b0;
        logic       f  = (phase == DIV - 1) && (slot == N - 1);
        logic [3:0] code;
        if (phase >= BLANK) begin
            code = d.codes[4*slot +: 4];
            s = (code > 4'd9 && !d.hex) ? 7'b0 : FONT[code];
            if (d.lzb && slot != 0 && (d.codes >> (4*slot)) == 16'h0 && (d.dps >> slot) == 4'h0)
                s = 7'b0;
            p = d.dps[slot];
            g = 4'b1 << slot;
        end
        return {s ^ {7{seg_low}}, p ^ seg_low, ~g, f};
    endfunction

    always @(negedge clk) begin
        if (m_ok) begin
            check("cycle_u0", {19'b0, seg0, dp0, dig0, fd0}, {19'b0, expect_out(m_cyc, m_disp, 1'b0)});
            check("cycle_u1", {19'b0, seg1, dp1, dig1, fd1}, {19'b0, expect_out(m_cyc, m_disp, 1'b1)});
            check("pending", {30'b0, up0, up1}, {30'b0, m_pv, m_pv});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic h, input logic z);
        data_in = d;
        dp_in   = p;
        hex_en  = h;
        lzb_en  = z;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    // Returns at the negedge inside a frame_done cycle (last cycle of a frame).
    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd0 && n < 4 * FRAME);
        check("frame_done_seen", {31'b0, fd0}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_u0", {19'b0, seg0, dp0, dig0, fd0}, {19'b0, 7'b0000000, 1'b0, 4'b1111, 1'b0});
        check("reset_u1", {19'b0, seg1, dp1, dig1, fd1}, {19'b0, 7'b1111111, 1'b1, 4'b1111, 1'b0});
        check("reset_pending", {31'b0, up0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: digit k = data_in[4k+3:4k], scan order 0..3, 2-cycle gap per slot
        do_load(16'h1234, 4'b0000, 1'b0, 1'b0);
        wait_frame();
        @(negedge clk);
        check("t1_gap_dig", {28'b0, dig0}, {28'b0, 4'b1111});
        repeat (2) @(negedge clk);
        check("t1_d0", {21'b0, dig0, seg0}, {21'b0, 4'b1110, 7'b0110011});
        repeat (8 * 3 + 3) @(negedge clk);
        check("t1_d3", {21'b0, dig0, seg0}, {21'b0, 4'b0111, 7'b0110000});

        // 2: hex + leading-zero blanking
        do_load(16'h00A5, 4'b0000, 1'b1, 1'b1);
        wait_frame();
        repeat (3) @(negedge clk);
        check("t2_d0", {25'b0, seg0}, {25'b0, 7'b1011011});
        repeat (8) @(negedge clk);
        check("t2_d1", {25'b0, seg0}, {25'b0, 7'b1110111});
        repeat (8) @(negedge clk);
        check("t2_d2_blank", {25'b0, seg0}, 32'd0);
        repeat (8) @(negedge clk);
        check("t2_d3_blank", {25'b0, seg0}, 32'd0);
        do_load(16'h00A5, 4'b0100, 1'b1, 1'b1);
        wait_frame();
        repeat (3 + 16) @(negedge clk);
        check("t2_d2_dp", {24'b0, seg0, dp0}, {24'b0, 7'b1111110, 1'b1});
        repeat (8) @(negedge clk);
        check("t2_d3_blank_dp", {24'b0, seg0, dp0}, 32'd0);

        // 3: tear-free update, latest pending load wins
        wait_frame();
        repeat (1 + 8 + 3) @(negedge clk);
        do_load(16'h1111, 4'b0000, 1'b0, 1'b0);
        check("t3_pending_set", {31'b0, up0}, 32'd1);
        repeat (6) @(negedge clk);
        do_load(16'h2222, 4'b0000, 1'b0, 1'b0);
        wait_frame();
        check("t3_pending_held", {31'b0, up0}, 32'd1);
        @(negedge clk);
        check("t3_pending_clear", {31'b0, up0}, 32'd0);
        repeat (2) @(negedge clk);
        check("t3_shows_2", {25'b0, seg0}, {25'b0, 7'b1101101});

        // 4: load on the frame_done cycle goes straight to the next frame
        wait_frame();
        do_load(16'h5678, 4'b0000, 1'b0, 1'b0);
        check("t4_no_pending", {31'b0, up0}, 32'd0);
        repeat (2) @(negedge clk);
        check("t4_d0_8", {25'b0, seg0}, {25'b0, 7'b1111111});

        // 5: reset mid-slot with a pending load
        wait_frame();
        repeat (1 + 8 + 4) @(negedge clk);
        do_load(16'h9999, 4'b1111, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_reset_out", {20'b0, dig0, seg0, up0}, {20'b0, 4'b1111, 7'b0000000, 1'b0});
        repeat (2) @(negedge clk);
        check("t5_restart_d0", {21'b0, dig0, seg0}, {21'b0, 4'b1110, 7'b1111110});
        wait_frame();
        repeat (3) @(negedge clk);
        check("t5_dropped", {21'b0, dig0, seg0}, {21'b0, 4'b1110, 7'b1111110});

        // 6: hex off blanks 0xC; active-low build inverts seg/dp
        do_load(16'h000C, 4'b0000, 1'b0, 1'b0);
        wait_frame();
        repeat (3) @(negedge clk);
        check("t6_c_blank", {21'b0, dig0, seg0}, {21'b0, 4'b1110, 7'b0000000});
        do_load(16'h0008, 4'b0000, 1'b0, 1'b0);
        wait_frame();
        repeat (3) @(negedge clk);
        check("t6_u1_8", {24'b0, seg1, dp1}, {24'b0, 7'b0000000, 1'b1});
        check("t6_u0_8", {25'b0, seg0}, {25'b0, 7'b1111111});

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
